// File: rtl/median_window_3x3.sv
// median_window_3x3
//   Streaming 3x3 neighbourhood generator for raster-ordered 8-bit grey
//   pixels. Two line buffers supply the two previous lines. Three 3-tap row
//   shift registers present the window. Each output row feeds one
//   three-input sorter unchanged.
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            synchronous, active-high reset
//   pix_in[7:0]    incoming pixel, raster order
//   pix_valid      pix_in accepted this cycle
//   sof            with pix_valid: pix_in is pixel (0,0) of a frame
//   win_00..02     top row    (line y-2), columns x-2..x
//   win_10..12     middle row (line y-1), columns x-2..x
//   win_20..22     bottom row (line y),   columns x-2..x
//   win_valid      window is a complete in-image neighbourhood
//   ctr_x, ctr_y   window centre (x-1, y-1)
//   eof            one-cycle pulse after the last pixel of a frame
module median_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [7:0]                    win_00,
    output logic [7:0]                    win_01,
    output logic [7:0]                    win_02,
    output logic [7:0]                    win_10,
    output logic [7:0]                    win_11,
    output logic [7:0]                    win_12,
    output logic [7:0]                    win_20,
    output logic [7:0]                    win_21,
    output logic [7:0]                    win_22,
    output logic                          win_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  ctr_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] ctr_y,
    output logic                          eof
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    // Position counters of the next pixel to be accepted
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Line buffers: r_lb1 holds line y-1, r_lb0 holds line y-2
    logic [7:0] r_lb0 [IMG_WIDTH];
    logic [7:0] r_lb1 [IMG_WIDTH];

    // Row shift registers, index 0 oldest column, index 2 newest
    logic [7:0] r_top [3];
    logic [7:0] r_mid [3];
    logic [7:0] r_bot [3];

    logic          r_win_valid;
    logic          r_eof;
    logic [XW-1:0] r_ctr_x;
    logic [YW-1:0] r_ctr_y;

    // Effective position of the pixel being accepted. sof overrides the counters.
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [7:0]    w_lb0_rd;
    logic [7:0]    w_lb1_rd;
    logic          w_accept;

    always_comb begin
        w_accept = pix_valid && !rst;
        w_x      = sof ? '0 : r_x;
        w_y      = sof ? '0 : r_y;
        w_lb0_rd = r_lb0[w_x];
        w_lb1_rd = r_lb1[w_x];
    end

    // Line buffers carry no reset. Their contents reach a valid window only
    // after two full lines of the current frame have been written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_x] <= w_lb1_rd;
            r_lb1[w_x] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_top[i] <= '0;
                r_mid[i] <= '0;
                r_bot[i] <= '0;
            end
            r_x         <= '0;
            r_y         <= '0;
            r_win_valid <= 1'b0;
            r_eof       <= 1'b0;
            r_ctr_x     <= '0;
            r_ctr_y     <= '0;
        end else begin
            r_win_valid <= 1'b0;
            r_eof       <= 1'b0;
            if (pix_valid) begin
                r_top[0] <= r_top[1];
                r_top[1] <= r_top[2];
                r_top[2] <= w_lb0_rd;
                r_mid[0] <= r_mid[1];
                r_mid[1] <= r_mid[2];
                r_mid[2] <= w_lb1_rd;
                r_bot[0] <= r_bot[1];
                r_bot[1] <= r_bot[2];
                r_bot[2] <= pix_in;

                r_win_valid <= (w_x >= X_TWO) && (w_y >= Y_TWO);
                // Centre is one column and one line behind the newest pixel.
                // Border values wrap, but they never accompany win_valid.
                r_ctr_x     <= w_x - X_ONE;
                r_ctr_y     <= w_y - Y_ONE;

                if (w_x == X_LAST) begin
                    r_x <= '0;
                    if (w_y == Y_LAST) begin
                        r_y   <= '0;
                        r_eof <= 1'b1;
                    end else begin
                        r_y <= w_y + Y_ONE;
                    end
                end else begin
                    r_x <= w_x + X_ONE;
                    r_y <= w_y;
                end
            end
        end
    end

    assign win_00    = r_top[0];
    assign win_01    = r_top[1];
    assign win_02    = r_top[2];
    assign win_10    = r_mid[0];
    assign win_11    = r_mid[1];
    assign win_12    = r_mid[2];
    assign win_20    = r_bot[0];
    assign win_21    = r_bot[1];
    assign win_22    = r_bot[2];
    assign win_valid = r_win_valid;
    assign eof       = r_eof;
    assign ctr_x     = r_ctr_x;
    assign ctr_y     = r_ctr_y;

endmodule

// File: tb/tb_median_window_3x3.sv
// tb_median_window_3x3
//   Directed and randomized checks of median_window_3x3 on a 4x4 image
//   against a frame-array reference model.
module tb_median_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
    logic       win_valid;
    logic [1:0] ctr_x;
    logic [1:0] ctr_y;
    logic       eof;

    always #5 clk = ~clk;

    median_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_00(win_00), .win_01(win_01), .win_02(win_02),
        .win_10(win_10), .win_11(win_11), .win_12(win_12),
        .win_20(win_20), .win_21(win_21), .win_22(win_22),
        .win_valid(win_valid), .ctr_x(ctr_x), .ctr_y(ctr_y), .eof(eof)
    );

    logic [7:0] ow [3][3];
    assign ow[0][0] = win_00; assign ow[0][1] = win_01; assign ow[0][2] = win_02;
    assign ow[1][0] = win_10; assign ow[1][1] = win_11; assign ow[1][2] = win_12;
    assign ow[2][0] = win_20; assign ow[2][1] = win_21; assign ow[2][2] = win_22;

    int checks = 0;
    int errors = 0;

    // Reference model: the picture as written so far, plus the pixel position
    logic [7:0] frame [H][W];
    int         mx = 0;
    int         my = 0;
    logic [7:0] ew [3][3];
    bit         known = 1'b0;
    bit         ev = 1'b0;
    bit         ee = 1'b0;
    bit         ctr_known = 1'b0;
    int         ecx = 0;
    int         ecy = 0;
    int         n_win = 0;
    int         n_eof = 0;
    int         last_px = 0;
    int         last_py = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [7:0] p);
        int px, py;
        rst = r; pix_valid = v; sof = s; pix_in = p;
        @(posedge clk);
        #1;
        if (r) begin
            mx = 0; my = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    ew[i][j] = 8'h00;
            known = 1'b1; ev = 1'b0; ee = 1'b0;
            ctr_known = 1'b1; ecx = 0; ecy = 0;
        end else if (v) begin
            px = s ? 0 : mx;
            py = s ? 0 : my;
            last_px = px; last_py = py;
            frame[py][px] = p;
            ev = (px >= 2) && (py >= 2);
            ee = (px == W - 1) && (py == H - 1);
            if (ev) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[i][j] = frame[py - 2 + i][px - 2 + j];
                known = 1'b1; ctr_known = 1'b1;
                ecx = px - 1; ecy = py - 1;
            end else begin
                known = 1'b0; ctr_known = 1'b0;
            end
            mx = (px + 1) % W;
            my = (px == W - 1) ? (py + 1) % H : py;
        end else begin
            ev = 1'b0; ee = 1'b0; ctr_known = 1'b0;
        end
        chk("win_valid", {31'd0, win_valid}, {31'd0, ev});
        chk("eof", {31'd0, eof}, {31'd0, ee});
        if (known)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("win_%0d%0d", i, j), {24'd0, ow[i][j]}, {24'd0, ew[i][j]});
        if (ctr_known) begin
            chk("ctr_x", {30'd0, ctr_x}, ecx);
            chk("ctr_y", {30'd0, ctr_y}, ecy);
        end
        if (win_valid === 1'b1) n_win++;
        if (eof === 1'b1) n_eof++;
    endtask

    function automatic logic [7:0] pv(input int x, input int y, input int base);
        return 8'(base + 16 * y + x);
    endfunction

    initial begin
        rst = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'h00;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame[y][x] = 8'h00;

        // Reset with random input and pix_valid high
        step(1, 1, 1'($urandom), 8'($urandom));
        step(1, 1, 1'($urandom), 8'($urandom));

        // Continuous frame with directed window contents
        n_win = 0; n_eof = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                step(0, 1, (x == 0 && y == 0), pv(x, y, 0));
                if (x == 2 && y == 2) begin
                    chk("first_valid", {31'd0, win_valid}, 1);
                    chk("first_w00", {24'd0, win_00}, 32'h00);
                    chk("first_w02", {24'd0, win_02}, 32'h02);
                    chk("first_w11", {24'd0, win_11}, 32'h11);
                    chk("first_w22", {24'd0, win_22}, 32'h22);
                    chk("first_ctr", {28'd0, ctr_x, ctr_y}, 32'h5);
                end
                if (x == 2 && y == 3) begin
                    chk("wrap_w00", {24'd0, win_00}, 32'h10);
                    chk("wrap_w12", {24'd0, win_12}, 32'h22);
                    chk("wrap_w20", {24'd0, win_20}, 32'h30);
                    chk("wrap_w22", {24'd0, win_22}, 32'h32);
                end
                if (x == 3 && y == 3) begin
                    chk("last_w22", {24'd0, win_22}, 32'h33);
                    chk("last_eof", {30'd0, eof, win_valid}, 32'h3);
                end
            end
        chk("cont_nwin", n_win, 4);
        chk("cont_neof", n_eof, 1);

        // Gapped frame: each pixel followed by an idle cycle
        n_win = 0; n_eof = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                step(0, 1, (x == 0 && y == 0), pv(x, y, 0));
                step(0, 0, 1'($urandom), 8'($urandom));
            end
        chk("gap_nwin", n_win, 4);
        chk("gap_neof", n_eof, 1);

        // sof mid-frame at position (1,2)
        for (int k = 0; k < 9; k++)
            step(0, 1, (k == 0), pv(k % W, k / W, 0));
        n_win = 0; n_eof = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                step(0, 1, (x == 0 && y == 0), pv(x, y, 8'h80));
                if (x == 1 && y == 2) chk("sof_nwin_early", n_win, 0);
            end
        chk("sof_nwin", n_win, 4);
        chk("sof_neof", n_eof, 1);

        // rst at pixel (3,2), then a frame without sof
        for (int k = 0; k < 11; k++)
            step(0, 1, (k == 0), pv(k % W, k / W, 8'h40));
        step(1, 1, 1'b0, pv(3, 2, 8'h40));
        n_win = 0; n_eof = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                step(0, 1, 1'b0, pv(x, y, 0));
        chk("rst_nwin", n_win, 4);
        chk("rst_neof", n_eof, 1);

        // Randomized: two frames of random pixels, random gaps, sof only on the first
        n_win = 0; n_eof = 0;
        begin
            int acc;
            bit v;
            acc = 0;
            for (int c = 0; c < 200 && acc < 2 * W * H; c++) begin
                v = ($urandom_range(0, 9) < 7);
                step(0, v, v && (acc == 0), 8'($urandom));
                if (v) acc++;
            end
            chk("rand_accepted", acc, 2 * W * H);
        end
        chk("rand_nwin", n_win, 8);
        chk("rand_neof", n_eof, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
